// File: rtl/aes_wbm_pkg.sv
// Shared definitions for the AES Wishbone initiator: register offsets,
// word counts, FSM state encoding and a 128-bit word selector.
`default_nettype none

package aes_wbm_pkg;

    localparam logic [7:0] OFS_KEY    = 8'h00;
    localparam logic [7:0] OFS_PT     = 8'h10;
    localparam logic [7:0] OFS_CTRL   = 8'h20;
    localparam logic [7:0] OFS_STATUS = 8'h24;
    localparam logic [7:0] OFS_CT     = 8'h28;

    localparam int unsigned KEY_WORDS = 4;
    localparam int unsigned PT_WORDS  = 4;
    localparam int unsigned CT_WORDS  = 4;

    localparam logic [31:0] CTRL_START = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_KEY    = 3'd1,
        WR_PT     = 3'd2,
        WR_CTRL   = 3'd3,
        POLL_RD   = 3'd4,
        POLL_WAIT = 3'd5,
        RD_CT     = 3'd6,
        FIN       = 3'd7
    } state_t;

    // Word 0 is the most significant 32 bits.
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] n);
        logic [31:0] w;
        case (n)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_wbm_xfer.sv
// Single-word Wishbone classic transfer engine with req/done handshake.
// Optional ack timeout enabled by macro AES_WBM_TIMEOUT_EN.
`default_nettype none

module aes_wbm_xfer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdat,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [31:0] adr,
    output logic [31:0] wdat,
    input  logic [31:0] dat_in,
    input  logic        ack
);

    logic active;
    logic abort;

    // A request is only accepted while no transfer is in flight, so the cycle
    // following an ack always shows cyc/stb low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            we     <= 1'b0;
            sel    <= 4'h0;
            adr    <= 32'h0;
            wdat   <= 32'h0;
        end else if (active) begin
            if (ack || abort) begin
                active <= 1'b0;
            end
        end else if (req) begin
            active <= 1'b1;
            we     <= req_we;
            sel    <= 4'hF;
            adr    <= req_adr;
            wdat   <= req_dat;
        end
    end

`ifdef AES_WBM_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!active || ack) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign abort = active && !ack && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign abort = 1'b0 & (TIMEOUT == 0);
`endif

    assign cyc  = active;
    assign stb  = active;
    assign done = active & ack;
    assign err  = abort;
    assign rdat = dat_in;

endmodule

`default_nettype wire

// File: rtl/aes_wb_master.sv
// Wishbone initiator that loads key/plaintext into an AES core, polls STATUS
// and reads back the ciphertext. Optional ack timeout: AES_WBM_TIMEOUT_EN.
`default_nettype none

module aes_wb_master #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned POLL_GAP = 4
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start_i,
    input  logic [127:0] key_i,
    input  logic [127:0] pt_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] ct_o,
    output logic         err_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i
);

    import aes_wbm_pkg::*;

    localparam int GW = (POLL_GAP > 2) ? $clog2(POLL_GAP - 1) : 1;

    state_t        state, next_state;
    logic [1:0]    idx;
    logic [GW-1:0] gap;
    logic [127:0]  key_q, pt_q;
    logic [95:0]   ct_buf;
    logic          req, req_we;
    logic [7:0]    req_ofs;
    logic [31:0]   req_dat;
    logic          xfer_done, xfer_err;
    logic [31:0]   xfer_rdat;

    always_comb begin
        next_state = state;
        req        = 1'b0;
        req_we     = 1'b0;
        req_ofs    = 8'h00;
        req_dat    = 32'h0;
        case (state)
            IDLE: begin
                if (start_i) next_state = WR_KEY;
            end
            WR_KEY: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_ofs = OFS_KEY + {4'h0, idx, 2'b00};
                req_dat = word_of(key_q, idx);
                if (xfer_done && idx == 2'(KEY_WORDS - 1)) next_state = WR_PT;
            end
            WR_PT: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_ofs = OFS_PT + {4'h0, idx, 2'b00};
                req_dat = word_of(pt_q, idx);
                if (xfer_done && idx == 2'(PT_WORDS - 1)) next_state = WR_CTRL;
            end
            WR_CTRL: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_ofs = OFS_CTRL;
                req_dat = CTRL_START;
                if (xfer_done) next_state = POLL_RD;
            end
            POLL_RD: begin
                req     = 1'b1;
                req_ofs = OFS_STATUS;
                if (xfer_done) begin
                    if (xfer_rdat[0])     next_state = RD_CT;
                    else if (POLL_GAP > 1) next_state = POLL_WAIT;
                    else                   next_state = POLL_RD;
                end
            end
            // The POLL_RD request cycle is itself idle, so wait one less here.
            POLL_WAIT: begin
                if (gap == GW'(POLL_GAP - 2)) next_state = POLL_RD;
            end
            RD_CT: begin
                req     = 1'b1;
                req_ofs = OFS_CT + {4'h0, idx, 2'b00};
                if (xfer_done && idx == 2'(CT_WORDS - 1)) next_state = FIN;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (xfer_err) next_state = IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            idx    <= 2'd0;
            gap    <= '0;
            key_q  <= 128'h0;
            pt_q   <= 128'h0;
            ct_buf <= 96'h0;
            ct_o   <= 128'h0;
            err_o  <= 1'b0;
        end else begin
            state <= next_state;
            err_o <= xfer_err;
            if (state == IDLE && start_i) begin
                key_q <= key_i;
                pt_q  <= pt_i;
            end
            if (state == IDLE || xfer_err) begin
                idx <= 2'd0;
            end else if (xfer_done && (state == WR_KEY || state == WR_PT || state == RD_CT)) begin
                idx <= idx + 2'd1;
            end
            gap <= (state == POLL_WAIT) ? gap + 1'b1 : '0;
            // ct_o only changes once all four words have arrived.
            if (state == RD_CT && xfer_done) begin
                case (idx)
                    2'd0:    ct_buf[95:64] <= xfer_rdat;
                    2'd1:    ct_buf[63:32] <= xfer_rdat;
                    2'd2:    ct_buf[31:0]  <= xfer_rdat;
                    default: ct_o          <= {ct_buf, xfer_rdat};
                endcase
            end
        end
    end

    assign busy_o = (state != IDLE) && (state != FIN);
    assign done_o = (state == FIN);

    aes_wbm_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .req     (req),
        .req_we  (req_we),
        .req_adr (BASE_ADR + {24'h0, req_ofs}),
        .req_dat (req_dat),
        .done    (xfer_done),
        .err     (xfer_err),
        .rdat    (xfer_rdat),
        .cyc     (wbm_cyc_o),
        .stb     (wbm_stb_o),
        .we      (wbm_we_o),
        .sel     (wbm_sel_o),
        .adr     (wbm_adr_o),
        .wdat    (wbm_dat_o),
        .dat_in  (wbm_dat_i),
        .ack     (wbm_ack_i)
    );

endmodule

`default_nettype wire

// File: tb/tb_aes_wb_master.sv
// Directed self-checking bench for aes_wb_master with a Wishbone responder
// model; the timeout scenario runs when AES_WBM_TIMEOUT_EN is defined.
`default_nettype none

module tb_aes_wb_master;

    localparam logic [31:0]  BASE   = 32'h3000_0000;
    localparam logic [31:0]  ADR_ST = 32'h3000_0024;
    localparam logic [31:0]  ADR_CT = 32'h3000_0020;
    localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst, start_i, busy_o, done_o, err_o;
    logic [127:0] key_i, pt_i, ct_o;
    logic         cyc, stb, we, ack;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_o, dat_i;

    int checks = 0, passes = 0, fails = 0;

    // Responder model configuration and logs
    int           lat = 1, poll_need = 1;
    bit           noack_ctrl = 1'b0, clr = 1'b0;
    logic [127:0] resp_ct = CT_A;
    int           wcnt, xfer_cnt, poll_cnt, ct_rd, done_cnt, wn, lowrun, status_gap;
    logic [31:0]  wlog_adr [16];
    logic [31:0]  wlog_dat [16];
    logic [31:0]  exp_ofs  [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    logic [31:0]  exp_dat  [9] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                                   32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 32'h1};

    always #5 clk = ~clk;

    aes_wb_master #(
        .BASE_ADR (BASE),
        .TIMEOUT  (16),
        .POLL_GAP (4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start_i),
        .key_i     (key_i),
        .pt_i      (pt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .ct_o      (ct_o),
        .err_o     (err_o),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    assign ack = cyc && stb && (wcnt == lat - 1) && !(noack_ctrl && adr == ADR_CT);

    always_comb begin
        int n;
        dat_i = 32'h0;
        n     = 0;
        if (adr == ADR_ST) begin
            dat_i = (poll_cnt >= poll_need - 1) ? 32'h1 : 32'h0;
        end else if (adr >= BASE + 32'h28 && adr <= BASE + 32'h34) begin
            n     = int'((adr - BASE - 32'h28) >> 2);
            dat_i = resp_ct[(3 - n) * 32 +: 32];
        end
    end

    always @(posedge clk) begin
        if (clr) begin
            wcnt <= 0; xfer_cnt <= 0; poll_cnt <= 0; ct_rd <= 0;
            done_cnt <= 0; wn <= 0; lowrun <= 0; status_gap <= 0;
        end else begin
            wcnt <= (cyc && stb && !ack) ? wcnt + 1 : 0;
            if (done_o) done_cnt <= done_cnt + 1;
            if (cyc && stb && ack) begin
                xfer_cnt <= xfer_cnt + 1;
                if (we) begin
                    if (wn < 16) begin
                        wlog_adr[wn] <= adr;
                        wlog_dat[wn] <= dat_o;
                    end
                    wn <= wn + 1;
                end else if (adr == ADR_ST) begin
                    poll_cnt <= poll_cnt + 1;
                end else begin
                    ct_rd <= ct_rd + 1;
                end
            end
            if (!cyc) begin
                lowrun <= lowrun + 1;
            end else begin
                if (lowrun != 0 && adr == ADR_ST) status_gap <= lowrun;
                lowrun <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Caller sets start_i=1 at a negedge; start is dropped after one cycle.
    task automatic run_until_done(input int budget, output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_cycles++;
        end
    endtask

    initial begin
        int  bc;
        bit  seen;
        rst = 1'b1; start_i = 1'b0; key_i = KEY_A; pt_i = PT_A;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_cyc",  {cyc, stb, we}, 0);
        check("reset_flags", {busy_o, done_o, err_o}, 0);
        check("reset_bus",  {sel, adr, dat_o}, 0);
        check("reset_ct",   ct_o, 128'h0);
        rst = 1'b0; clr = 1'b0;
        @(negedge clk);

        // FIPS-197 vector, single-cycle ack, done on first poll
        clear_logs();
        lat = 1; poll_need = 1; resp_ct = CT_A;
        start_i = 1'b1;
        run_until_done(200, bc, seen);
        check("a_done_seen", seen, 1);
        check("a_latency", bc, 28);
        check("a_busy_at_done", busy_o, 0);
        check("a_ct", ct_o, CT_A);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("a_wadr%0d", i), wlog_adr[i], BASE + exp_ofs[i]);
            check($sformatf("a_wdat%0d", i), wlog_dat[i], exp_dat[i]);
        end
        @(negedge clk);
        check("a_done_pulse", done_o, 0);
        check("a_xfers", xfer_cnt, 14);
        check("a_done_cnt", done_cnt, 1);
        check("a_sel_held", sel, 4'hF);

        // 3-cycle ack latency, STATUS ready on fifth poll
        clear_logs();
        lat = 3; poll_need = 5; resp_ct = CT_B; key_i = KEY_B; pt_i = PT_B;
        start_i = 1'b1;
        run_until_done(600, bc, seen);
        check("b_done_seen", seen, 1);
        check("b_ct", ct_o, CT_B);
        @(negedge clk);
        check("b_polls", poll_cnt, 5);
        check("b_poll_gap", status_gap, 4);
        check("b_xfers", xfer_cnt, 18);
        check("b_key0", wlog_dat[0], 32'h2b7e1516);
        check("b_pt3", wlog_dat[7], 32'he0370734);
        check("b_done_cnt", done_cnt, 1);

        // start retrigger and key/pt changes while busy must be ignored
        clear_logs();
        lat = 1; poll_need = 1; resp_ct = CT_A; key_i = KEY_A; pt_i = PT_A;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        key_i = ~KEY_A; pt_i = ~PT_A;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cyc && adr == BASE + 32'h14) begin
                seen = 1'b1;
                break;
            end
        end
        check("c_in_wr_pt", seen, 1);
        start_i = 1'b1;
        run_until_done(200, bc, seen);
        check("c_done_seen", seen, 1);
        repeat (4) @(negedge clk);
        check("c_xfers", xfer_cnt, 14);
        check("c_done_cnt", done_cnt, 1);
        check("c_idle", busy_o, 0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("c_wdat%0d", i), wlog_dat[i], exp_dat[i]);
        end

        // asynchronous reset during the third ciphertext read
        clear_logs();
        resp_ct = CT_B;
        start_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (ct_rd == 2 && cyc) begin
                seen = 1'b1;
                break;
            end
        end
        check("d_reached_rd_ct", seen, 1);
        check("d_ct_before", ct_o, CT_A);
        #1 rst = 1'b1;
        #1;
        check("d_cyc_async", {cyc, stb}, 0);
        check("d_ct_cleared", ct_o, 128'h0);
        check("d_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        start_i = 1'b1;
        run_until_done(200, bc, seen);
        check("d_restart_done", seen, 1);
        check("d_restart_ct", ct_o, CT_B);

`ifdef AES_WBM_TIMEOUT_EN
        // responder never acks CTRL
        clear_logs();
        resp_ct = CT_A; noack_ctrl = 1'b1;
        start_i = 1'b1;
        seen = 1'b0; bc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (err_o) begin
                seen = 1'b1;
                break;
            end
            if (cyc && adr == ADR_CT) bc++;
        end
        check("t_err_seen", seen, 1);
        check("t_wait_cycles", bc, 16);
        check("t_cyc_low", cyc, 0);
        check("t_busy_low", busy_o, 0);
        @(negedge clk);
        check("t_err_pulse", err_o, 0);
        repeat (4) @(negedge clk);
        check("t_no_done", done_cnt, 0);
        check("t_ct_kept", ct_o, CT_B);
        noack_ctrl = 1'b0;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_wb_master.md
AES_WB_MASTER -- requirements
Module: aes_wb_master

Interface
REQ-001 Parameter BASE_ADR, default 32'h3000_0000: Wishbone base address of the AES core register block.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for ack per transfer (used only with AES_WBM_TIMEOUT_EN).
REQ-003 Parameter POLL_GAP, default 4: idle cycles between STATUS polls.
REQ-004 wb_clk_i  in  1  sole clock, rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  request one encryption; sampled only in IDLE.
REQ-007 key_i  in  128  cipher key; pt_i  in  128  plaintext; both captured on accepted start_i.
REQ-008 busy_o  out  1  high from the cycle after start is accepted until the cycle done_o/err_o pulses.
REQ-009 done_o  out  1  one-cycle pulse when ct_o is valid.
REQ-010 ct_o  out  128  ciphertext; held until the next accepted start_i.
REQ-011 err_o  out  1  one-cycle pulse on ack timeout.
REQ-012 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each; wbm_sel_o  out  4; wbm_adr_o  out  32; wbm_dat_o  out  32: Wishbone classic initiator outputs.
REQ-013 wbm_dat_i  in  32; wbm_ack_i  in  1: Wishbone responder return path.

Function
REQ-014 Register map (byte offsets from BASE_ADR) SHALL be: KEY0-3 0x00-0x0C, PT0-3 0x10-0x1C, CTRL 0x20 (bit0 = start), STATUS 0x24 (bit0 = done), CT0-3 0x28-0x34.
REQ-015 Word n SHALL carry bits [127-32n : 96-32n] (most significant word at lowest offset), for key, plaintext and ciphertext.
REQ-016 FSM states SHALL be IDLE, WR_KEY, WR_PT, WR_CTRL, POLL_RD, POLL_WAIT, RD_CT, FIN.
REQ-017 IDLE -> WR_KEY on start_i; WR_KEY (4 writes) -> WR_PT (4 writes) -> WR_CTRL (write 32'h1) -> POLL_RD.
REQ-018 POLL_RD reads STATUS; bit0=1 -> RD_CT, else POLL_WAIT for POLL_GAP cycles -> POLL_RD.
REQ-019 RD_CT performs 4 reads into ct_o; FIN asserts done_o for one cycle -> IDLE.
REQ-020 Each transfer SHALL assert cyc/stb with stable adr/dat/we and sel=4'hF until the ack cycle; cyc/stb SHALL drop for exactly one cycle after each ack.
REQ-021 Read data SHALL be captured in the ack cycle; ack SHALL be ignored while stb is low.
REQ-022 Minimum latency start_i->done_o with single-cycle ack and done on first poll: 28 cycles (14 transfers x 2 cycles).
REQ-023 start_i while busy_o SHALL be ignored; key/pt changes while busy SHALL NOT affect the operation in progress.

Reset
REQ-024 On wb_rst_i (any time, including mid-transfer): state IDLE; cyc, stb, we, busy_o, done_o, err_o = 0; sel, adr, dat_o = 0; ct_o = 128'h0; all counters cleared.

Configuration
REQ-025 Macro AES_WBM_TIMEOUT_EN: when defined, a per-transfer counter SHALL abort after TIMEOUT cycles without ack: drop cyc/stb, pulse err_o, return to IDLE, ct_o unchanged; when undefined, transfers wait indefinitely and err_o is tied 0.

Structure
REQ-026 Package aes_wbm_pkg SHALL hold the register offset constants, the FSM state enum, and word-count constants.
REQ-027 Sub-module aes_wbm_xfer SHALL implement one single-word Wishbone transfer (req/done handshake, optional timeout); aes_wb_master sequences it.

Verification
REQ-028 FIPS-197: key 000102..0f, pt 00112233..ff, responder model -> writes in order 0x00..0x20, ct_o = 69c4e0d86a7b0430d8cdb78070b4c55a, one done_o pulse.
REQ-029 Responder with 3-cycle ack latency and STATUS done on 5th poll -> exactly 5 STATUS reads, POLL_GAP=4 idle cycles between polls, correct ct_o.
REQ-030 start_i pulsed again during WR_PT -> ignored, exactly 14+polls transfers, one done_o.
REQ-031 wb_rst_i asserted mid-RD_CT (after 2 reads) -> cyc/stb low same cycle asynchronously, ct_o = 0, next start completes normally.
REQ-032 AES_WBM_TIMEOUT_EN, TIMEOUT=16, responder never acks WR_CTRL -> err_o pulses after 16 wait cycles, cyc low, busy_o low, no done_o.
